// File: rtl/adc_pkg.sv
// Shared types, pointer constants and config-byte helper for the ADS1115 scanner.
package adc_pkg;

    typedef enum logic [3:0] {
        IDLE,
        CFG_START,
        CFG_WAIT,
        CONV_DELAY,
        PTR_START,
        PTR_WAIT,
        RD_START,
        RD_WAIT,
        PUBLISH,
        NEXT
    } scan_state_t;

    localparam logic [7:0] PTR_CONV = 8'h00;
    localparam logic [7:0] PTR_CFG  = 8'h01;

    // Config register {MSB, LSB}: start single-shot, AINch vs GND, PGA,
    // single-shot mode; data rate, comparator defaults, comparator disabled.
    function automatic logic [15:0] ads_cfg_bytes(input logic [1:0] ch,
                                                  input logic [2:0] pga,
                                                  input logic [2:0] dr);
        return {1'b1, 1'b1, ch, pga, 1'b1, dr, 3'b000, 2'b11};
    endfunction

endpackage

// File: rtl/adc_scan_fsm.sv
// Round-robin ADS1115 channel scanner: config write, conversion wait,
// pointer write, 2-byte read, publish. Sticky timeout on stalled transactions.
// Handshake: o_i2c_transaction_start is a one-cycle request; command fields
// are valid in that cycle and held until i_i2c_transaction_done is seen in
// the matching wait state. o_sample_valid is a one-cycle strobe, no back-pressure.
module adc_scan_fsm
    import adc_pkg::*;
#(
    parameter int          MAX_BYTES_PER_TRANSACTION = 3,
    parameter int          NUM_CHANNELS              = 4,
    parameter logic [6:0]  SLAVE_ADDR                = 7'h48,
    parameter logic [2:0]  PGA_BITS                  = 3'b001,
    parameter logic [2:0]  DR_BITS                   = 3'b111,
    parameter int          CONV_WAIT_CYCLES          = 150000,
    parameter int          TIMEOUT_CYCLES            = 2000000,
    localparam int         BN_W = $clog2(MAX_BYTES_PER_TRANSACTION + 1)
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_enable,
    input  logic [NUM_CHANNELS-1:0] i_channel_en,
    input  logic              i_i2c_transaction_done,
    input  logic [7:0]        i_i2c_master_dout [0:MAX_BYTES_PER_TRANSACTION-1],
    output logic              o_i2c_transaction_start,
    output logic              o_i2c_transaction_rd_nwr,
    output logic [6:0]        o_i2c_transaction_slave_addr,
    output logic [7:0]        o_i2c_master_din [0:MAX_BYTES_PER_TRANSACTION-1],
    output logic [BN_W-1:0]   o_i2c_transaction_bytes_num,
    output logic              o_sample_valid,
    output logic [1:0]        o_sample_channel,
    output logic [15:0]       o_sample_data,
    output logic              o_timeout_err,
    output scan_state_t       o_state
);

    localparam int CNT_MAX = (CONV_WAIT_CYCLES > TIMEOUT_CYCLES) ? CONV_WAIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    scan_state_t       r_state;
    logic              r_start;
    logic              r_rd_nwr;
    logic [BN_W-1:0]   r_bytes;
    logic [7:0]        r_din [0:MAX_BYTES_PER_TRANSACTION-1];
    logic              r_valid;
    logic [1:0]        r_sample_ch;
    logic [15:0]       r_sample_data;
    logic              r_timeout_err;
    logic [1:0]        r_ch;
    logic [CNT_W-1:0]  r_cnt;       // conversion delay in CONV_DELAY, timeout elsewhere

    logic [1:0]        w_low_ch;
    logic [1:0]        w_next_ch;
    logic [1:0]        w_sel_ch;
    logic [15:0]       w_cfg;
    logic              w_cnt_to;
    logic              w_cnt_conv;

    // Lowest enabled channel, and next enabled channel strictly above r_ch with wrap.
    always_comb begin
        int idx;
        idx       = 0;
        w_low_ch  = 2'd0;
        w_next_ch = r_ch;
        for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
            if (i_channel_en[i]) w_low_ch = 2'(i);
        end
        for (int k = NUM_CHANNELS; k >= 1; k--) begin
            idx = int'(r_ch) + k;
            if (idx >= NUM_CHANNELS) idx = idx - NUM_CHANNELS;
            if (i_channel_en[idx]) w_next_ch = 2'(idx);
        end
    end

    assign w_sel_ch   = (r_state == IDLE) ? w_low_ch : w_next_ch;
    assign w_cfg      = ads_cfg_bytes(w_sel_ch, PGA_BITS, DR_BITS);
    assign w_cnt_to   = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign w_cnt_conv = (r_cnt == CNT_W'(CONV_WAIT_CYCLES - 1));

    // Scan sequencer with registered command and sample outputs.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state       <= IDLE;
            r_start       <= 1'b0;
            r_rd_nwr      <= 1'b0;
            r_bytes       <= '0;
            for (int i = 0; i < MAX_BYTES_PER_TRANSACTION; i++) r_din[i] <= 8'h00;
            r_valid       <= 1'b0;
            r_sample_ch   <= 2'd0;
            r_sample_data <= 16'h0000;
            r_timeout_err <= 1'b0;
            r_ch          <= 2'd0;
            r_cnt         <= '0;
        end else begin
            r_start <= 1'b0;
            r_valid <= 1'b0;
            case (r_state)
                IDLE, NEXT: begin
                    if (i_enable && (|i_channel_en)) begin
                        r_ch     <= w_sel_ch;
                        r_state  <= CFG_START;
                        r_start  <= 1'b1;
                        r_rd_nwr <= 1'b0;
                        r_bytes  <= BN_W'(3);
                        for (int i = 0; i < MAX_BYTES_PER_TRANSACTION; i++) r_din[i] <= 8'h00;
                        r_din[0] <= PTR_CFG;
                        r_din[1] <= w_cfg[15:8];
                        r_din[2] <= w_cfg[7:0];
                        r_cnt    <= '0;
                    end else begin
                        r_state  <= IDLE;
                    end
                end
                CFG_START: begin
                    r_cnt   <= r_cnt + 1'b1;
                    r_state <= CFG_WAIT;
                end
                PTR_START: begin
                    r_cnt   <= r_cnt + 1'b1;
                    r_state <= PTR_WAIT;
                end
                RD_START: begin
                    r_cnt   <= r_cnt + 1'b1;
                    r_state <= RD_WAIT;
                end
                CFG_WAIT, PTR_WAIT, RD_WAIT: begin
                    if (i_i2c_transaction_done) begin
                        r_cnt <= '0;
                        if (r_state == CFG_WAIT) begin
                            r_state <= CONV_DELAY;
                        end else if (r_state == PTR_WAIT) begin
                            r_state  <= RD_START;
                            r_start  <= 1'b1;
                            r_rd_nwr <= 1'b1;
                            r_bytes  <= BN_W'(2);
                            for (int i = 0; i < MAX_BYTES_PER_TRANSACTION; i++) r_din[i] <= 8'h00;
                        end else begin
                            r_state       <= PUBLISH;
                            r_valid       <= 1'b1;
                            r_sample_ch   <= r_ch;
                            r_sample_data <= {i_i2c_master_dout[0], i_i2c_master_dout[1]};
                        end
                    end else if (w_cnt_to) begin
                        r_timeout_err <= 1'b1;
                        r_state       <= NEXT;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                CONV_DELAY: begin
                    if (w_cnt_conv) begin
                        r_state  <= PTR_START;
                        r_start  <= 1'b1;
                        r_rd_nwr <= 1'b0;
                        r_bytes  <= BN_W'(1);
                        for (int i = 0; i < MAX_BYTES_PER_TRANSACTION; i++) r_din[i] <= 8'h00;
                        r_din[0] <= PTR_CONV;
                        r_cnt    <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                PUBLISH: begin
                    r_state <= NEXT;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_i2c_transaction_start      = r_start;
    assign o_i2c_transaction_rd_nwr     = r_rd_nwr;
    assign o_i2c_transaction_slave_addr = SLAVE_ADDR;
    assign o_i2c_master_din             = r_din;
    assign o_i2c_transaction_bytes_num  = r_bytes;
    assign o_sample_valid               = r_valid;
    assign o_sample_channel             = r_sample_ch;
    assign o_sample_data                = r_sample_data;
    assign o_timeout_err                = r_timeout_err;
    assign o_state                      = r_state;

endmodule
